// File: rtl/upc_word_scroller_if.sv
// rtl/upc_word_scroller_if.sv - item code / display bundle for the UPC word scroller
// Purpose: groups the word scroller's control inputs and display outputs.
// Ports (signals):
//   upc[2:0]                  item code
//   hold                      freeze scroll position and divider
//   flash                     blink request (used only with SEG_WORD_BLINK_EN)
//   leds[7*NUM_DISPLAYS-1:0]  active-low segments, digit k at [7k+6:7k]
//   scrolling                 current word is longer than the display
// Modports: master drives upc/hold/flash; slave (the scroller) drives leds/scrolling.
interface upc_word_scroller_if #(
  parameter int NUM_DISPLAYS = 6
);
  logic [2:0]                upc;
  logic                      hold;
  logic                      flash;
  logic [7*NUM_DISPLAYS-1:0] leds;
  logic                      scrolling;

  modport master (output upc, hold, flash, input leds, scrolling);
  modport slave  (input upc, hold, flash, output leds, scrolling);
endinterface

// File: rtl/upc_word_scroller.sv
// rtl/upc_word_scroller.sv - registered scrolling product-word 7-segment driver
// Purpose: shows the word for the current item code on NUM_DISPLAYS active-low
//   digits; short words are static and left-aligned, long words scroll circularly
//   one character per SCROLL_DIV clocks, with two blanks between repeats.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    upc_word_scroller_if.slave (upc, hold, flash in; leds, scrolling out)
// Optional feature: define SEG_WORD_BLINK_EN to build the flash/blink logic
//   (phase toggles every BLINK_DIV clocks; leds blank in the off phase while flash).
module upc_word_scroller #(
  parameter int NUM_DISPLAYS = 6,
  parameter int SCROLL_DIV   = 25000000,
  parameter int BLINK_DIV    = 12500000
) (
  input logic             clk,
  input logic             reset,
  upc_word_scroller_if.slave bus
);
  localparam int               DIV_W    = $clog2(SCROLL_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam logic [3:0]       ND4      = 4'(NUM_DISPLAYS);

  localparam logic [6:0] GL_G  = 7'b0010000;
  localparam logic [6:0] GL_O  = 7'b1000000;
  localparam logic [6:0] GL_A  = 7'b0001000;
  localparam logic [6:0] GL_T  = 7'b0000111;
  localparam logic [6:0] GL_F  = 7'b0001110;
  localparam logic [6:0] GL_I  = 7'b1111011;
  localparam logic [6:0] GL_S  = 7'b0010010;
  localparam logic [6:0] GL_H  = 7'b0001001;
  localparam logic [6:0] GL_P  = 7'b0001100;
  localparam logic [6:0] GL_U  = 7'b1000001;
  localparam logic [6:0] GL_C  = 7'b1000110;
  localparam logic [6:0] GL_B  = 7'b0000011;
  localparam logic [6:0] GL_E  = 7'b0000110;
  localparam logic [6:0] GL_BL = 7'b1111111;

  typedef enum logic [1:0] {ST_BLANK, ST_STATIC, ST_SCROLL} state_t;

  logic [2:0]                code_q;
  logic [2:0]                pos;
  logic [DIV_W-1:0]          div;
  logic [7*NUM_DISPLAYS-1:0] leds_q;
  logic                      scrolling_q;

  state_t                    state;
  logic [7:0][6:0]           word;     // word[i] = glyph of character i, blank past the end
  logic [3:0]                len;
  logic [3:0]                l_total;  // word plus two trailing blanks
  logic [3:0]                idx;
  logic [7*NUM_DISPLAYS-1:0] window;
  logic                      blank_now;

  // Word table and state decode; the state is a pure function of code_q.
  always_comb begin
    word = {8{GL_BL}};
    len  = 4'd0;
    case (code_q)
      3'b000: begin word[0] = GL_G; word[1] = GL_O; word[2] = GL_A; word[3] = GL_T; len = 4'd4; end
      3'b001: begin word[0] = GL_F; word[1] = GL_I; word[2] = GL_S; word[3] = GL_H; len = 4'd4; end
      3'b011: begin
        word[0] = GL_P; word[1] = GL_O; word[2] = GL_T;
        word[3] = GL_A; word[4] = GL_T; word[5] = GL_O; len = 4'd6;
      end
      3'b100: begin
        word[0] = GL_G; word[1] = GL_U; word[2] = GL_C; word[3] = GL_C; word[4] = GL_I; len = 4'd5;
      end
      3'b101: begin
        word[0] = GL_B; word[1] = GL_E; word[2] = GL_A; word[3] = GL_T; word[4] = GL_S; len = 4'd5;
      end
      3'b110: begin word[0] = GL_P; word[1] = GL_E; word[2] = GL_E; word[3] = GL_P; len = 4'd4; end
      default: len = 4'd0;
    endcase
    l_total = len + 4'd2;
    if (len == 4'd0)     state = ST_BLANK;
    else if (len <= ND4) state = ST_STATIC;
    else                 state = ST_SCROLL;
  end

  // Window: leftmost digit shows S[pos]. Only a scrolling word wraps; a static
  // word on a wide display just runs into blanks. pos + j < 2*L when scrolling,
  // so one subtraction is enough for the modulo.
  always_comb begin
    window = '1;
    idx    = '0;
    for (int j = 0; j < NUM_DISPLAYS; j++) begin
      idx = {1'b0, pos} + 4'(j);
      if (state == ST_SCROLL && idx >= l_total) idx = idx - l_total;
      if (idx < len) window[7*(NUM_DISPLAYS-1-j) +: 7] = word[idx[2:0]];
    end
  end

  // Code capture and scroll stepping; a code change beats hold and a step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q <= 3'b111;
      pos    <= '0;
      div    <= '0;
    end else if (bus.upc != code_q) begin
      code_q <= bus.upc;
      pos    <= '0;
      div    <= '0;
    end else if (state != ST_SCROLL) begin
      pos <= '0;
      div <= '0;
    end else if (!bus.hold) begin
      if (div == DIV_LAST) begin
        div <= '0;
        pos <= ({1'b0, pos} == l_total - 4'd1) ? 3'd0 : pos + 3'd1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

`ifdef SEG_WORD_BLINK_EN
  localparam int                 BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;

  // Counter and phase idle at zero whenever flash is low, so the word
  // reappears on the very next leds update after flash drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || !bus.flash) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank_now = bus.flash & blink_off;
`else
  assign blank_now = bus.flash & 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q      <= '1;
      scrolling_q <= 1'b0;
    end else begin
      leds_q      <= blank_now ? '1 : window;
      scrolling_q <= (state == ST_SCROLL);
    end
  end

  assign bus.leds      = leds_q;
  assign bus.scrolling = scrolling_q;
endmodule
